// File: rtl/inst_mem_pkg.sv
// inst_mem_pkg: shared defaults, controller state type and byte-to-word address helper
package inst_mem_pkg;
  localparam int ADDR_W_DEF        = 16;
  localparam int DATA_W_DEF        = 32;
  localparam int MAX_PATCH_RUN_DEF = 4;
  localparam int WORD_OFFSET_BITS  = 2;
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
  function automatic logic [31-WORD_OFFSET_BITS:0] byte_to_word(input logic [31:0] byte_addr);
    return byte_addr[31:WORD_OFFSET_BITS];
  endfunction
endpackage

// File: rtl/inst_mem_if.sv
// inst_mem_if: loader, debug-patch and IF-stage signals around the instruction memory controller
interface inst_mem_if #(
  parameter int ADDR_W = inst_mem_pkg::ADDR_W_DEF,
  parameter int DATA_W = inst_mem_pkg::DATA_W_DEF
) ();
  logic              boot_skip;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;
  logic              reload;
  logic              patch_valid;
  logic [31:0]       patch_addr;
  logic [DATA_W-1:0] patch_data;
  logic              patch_ready;
  logic              fetch_req;
  logic [31:0]       fetch_addr;
  logic [DATA_W-1:0] fetch_inst;
  logic              fetch_valid;
  logic              fetch_stall;
  logic              cpu_rst_hold;
  logic              err_misalign;
  logic              err_overflow;
  logic [ADDR_W:0]   load_count;
  modport master (
    output boot_skip, load_valid, load_data, load_last, reload,
    output patch_valid, patch_addr, patch_data, fetch_req, fetch_addr,
    input  load_ready, patch_ready, fetch_inst, fetch_valid, fetch_stall,
    input  cpu_rst_hold, err_misalign, err_overflow, load_count
  );
  modport slave (
    input  boot_skip, load_valid, load_data, load_last, reload,
    input  patch_valid, patch_addr, patch_data, fetch_req, fetch_addr,
    output load_ready, patch_ready, fetch_inst, fetch_valid, fetch_stall,
    output cpu_rst_hold, err_misalign, err_overflow, load_count
  );
endinterface

// File: rtl/inst_mem_sp.sv
// inst_mem_sp: single-port synchronous RAM, write on we, registered read-first data one cycle later
module inst_mem_sp #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  always_ff @(posedge clk) begin
    if (we) r_mem[addr] <= wdata;
    rdata <= r_mem[addr];
  end
endmodule

// File: rtl/inst_mem_ctrl.sv
// inst_mem_ctrl: boot-loads the instruction memory, releases the core, then arbitrates
// the single memory port between debug patches and IF-stage fetches
module inst_mem_ctrl import inst_mem_pkg::*; #(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int MAX_PATCH_RUN = MAX_PATCH_RUN_DEF
) (
  input logic       clk,
  input logic       rst,
  inst_mem_if.slave bus
);
  localparam int PW = $clog2(MAX_PATCH_RUN + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  state_t            r_state;
  logic [ADDR_W:0]   r_load_cnt;
  logic [PW-1:0]     r_prun;
  logic              r_fetch_valid;
  logic              r_misalign;
  logic              r_overflow;
  logic              w_run;
  logic              w_load_we;
  logic              w_at_end;
  logic              w_force_fetch;
  logic              w_patch_gnt;
  logic              w_fetch_gnt;
  logic              w_we;
  logic [ADDR_W-1:0] w_load_addr;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_rdata;
  always_comb begin
    w_run         = r_state == RUN;
    w_load_addr   = r_load_cnt[ADDR_W-1:0];
    w_load_we     = r_state == LOAD && bus.load_valid;
    w_at_end      = w_load_addr == LAST_ADDR;
    w_force_fetch = r_prun >= PW'(MAX_PATCH_RUN) && bus.fetch_req;
    w_patch_gnt   = w_run && !bus.reload && bus.patch_valid && !w_force_fetch;
    w_fetch_gnt   = w_run && !bus.reload && bus.fetch_req && !w_patch_gnt;
    w_we          = w_load_we || w_patch_gnt;
    w_addr        = w_load_we ? w_load_addr
                  : ADDR_W'(byte_to_word(w_patch_gnt ? bus.patch_addr : bus.fetch_addr));
    w_wdata       = w_load_we ? bus.load_data : bus.patch_data;
  end
  inst_mem_sp #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mem (
    .clk   (clk),
    .we    (w_we),
    .addr  (w_addr),
    .wdata (w_wdata),
    .rdata (w_rdata)
  );
  // the RAM output register has no reset, so gate it to keep fetch_inst at zero outside a valid beat
  assign bus.fetch_inst   = r_fetch_valid ? w_rdata : '0;
  assign bus.fetch_valid  = r_fetch_valid;
  assign bus.err_misalign = r_misalign;
  assign bus.err_overflow = r_overflow;
  assign bus.load_count   = r_load_cnt;
  assign bus.load_ready   = r_state == LOAD;
  assign bus.cpu_rst_hold = !w_run;
  assign bus.patch_ready  = w_patch_gnt;
  assign bus.fetch_stall  = w_run && bus.fetch_req && !w_fetch_gnt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_load_cnt    <= '0;
      r_prun        <= '0;
      r_fetch_valid <= 1'b0;
      r_misalign    <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_fetch_valid <= w_fetch_gnt;
      r_misalign    <= w_fetch_gnt && |bus.fetch_addr[1:0];
      // saturating run of consecutive patch grants; anything else restarts it
      r_prun <= !w_patch_gnt ? '0 : r_prun == PW'(MAX_PATCH_RUN) ? r_prun : r_prun + 1'b1;
      case (r_state)
        IDLE: begin
          if (bus.boot_skip) begin
            r_state <= RUN;
          end else if (bus.load_valid) begin
            r_state    <= LOAD;
            r_load_cnt <= '0;
            r_overflow <= 1'b0;
          end
        end
        LOAD: begin
          if (bus.load_valid) begin
            r_load_cnt <= r_load_cnt + 1'b1;
            if (bus.load_last || w_at_end) r_state <= RUN;
            if (!bus.load_last && w_at_end) r_overflow <= 1'b1;
          end
        end
        RUN: begin
          if (bus.reload) begin
            r_state    <= LOAD;
            r_load_cnt <= '0;
            r_overflow <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_inst_mem_ctrl.sv
// tb_inst_mem_ctrl: randomized stimulus against a queue/array reference model, scoreboard monitor on negedge
module tb_inst_mem_ctrl;
  localparam int MAXP = 4;
  typedef struct packed {
    logic        pr;
    logic        st;
    logic        lr;
    logic        hold;
    logic        fv;
    logic        ovf;
    logic [16:0] lc;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  always #5 clk = ~clk;
  inst_mem_if bus ();
  inst_mem_if #(.ADDR_W(2)) bus2 ();
  inst_mem_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  inst_mem_ctrl #(.ADDR_W(2)) dut2 (.clk(clk), .rst(rst2), .bus(bus2));
  logic [31:0] mem_m [int];
  int known[$];
  int ph = 0;
  int lcnt = 0;
  int streak = 0;
  bit prev_fg = 1'b0;
  bit ovf = 1'b0;
  bit last_pg = 1'b0;
  exp_t cq[$];
  logic [32:0] fq[$];
  logic [31:0] words[$];
  exp_t me;
  logic [32:0] mf;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    ph = 0; lcnt = 0; streak = 0; prev_fg = 1'b0; ovf = 1'b0;
    cq.delete(); fq.delete();
  endtask
  // one clock of the reference model: expectations for this cycle, then advance
  task automatic step();
    exp_t e;
    bit pg, fg;
    int wa;
    e.hold = ph != 2; e.lr = ph == 1; e.fv = prev_fg; e.ovf = ovf; e.lc = 17'(lcnt);
    pg = ph == 2 && !bus.reload && bus.patch_valid && !(streak >= MAXP && bus.fetch_req);
    fg = ph == 2 && !bus.reload && bus.fetch_req && !pg;
    e.pr = pg;
    e.st = ph == 2 && bus.fetch_req && !fg;
    if (fg) begin
      wa = int'(bus.fetch_addr[17:2]);
      fq.push_back({|bus.fetch_addr[1:0], mem_m.exists(wa) ? mem_m[wa] : 32'h0});
    end
    if (pg) begin
      wa = int'(bus.patch_addr[17:2]);
      mem_m[wa] = bus.patch_data; known.push_back(wa);
    end
    streak = pg ? streak + 1 : 0;
    prev_fg = fg; last_pg = pg;
    case (ph)
      0: if (bus.boot_skip) ph = 2; else if (bus.load_valid) begin ph = 1; lcnt = 0; ovf = 1'b0; end
      1: if (bus.load_valid) begin
        mem_m[lcnt] = bus.load_data; known.push_back(lcnt); lcnt++;
        if (bus.load_last || lcnt == 65536) ph = 2;
        if (!bus.load_last && lcnt == 65536) ovf = 1'b1;
      end
      2: if (bus.reload) begin ph = 1; lcnt = 0; ovf = 1'b0; end
      default: ;
    endcase
    cq.push_back(e);
    @(posedge clk); #1;
  endtask
  always @(negedge clk) begin
    if (mon_en) begin
      if (cq.size() == 0) begin
        checks++; errors++;
        $display("FAIL mon_queue: got no expectation, expected one per cycle");
      end else begin
        me = cq.pop_front();
        chk("patch_ready", 64'(bus.patch_ready), 64'(me.pr));
        chk("fetch_stall", 64'(bus.fetch_stall), 64'(me.st));
        chk("load_ready", 64'(bus.load_ready), 64'(me.lr));
        chk("cpu_rst_hold", 64'(bus.cpu_rst_hold), 64'(me.hold));
        chk("fetch_valid", 64'(bus.fetch_valid), 64'(me.fv));
        chk("err_overflow", 64'(bus.err_overflow), 64'(me.ovf));
        chk("load_count", 64'(bus.load_count), 64'(me.lc));
        if (me.fv && fq.size() > 0) begin
          mf = fq.pop_front();
          chk("fetch_inst", 64'(bus.fetch_inst), 64'(mf[31:0]));
          chk("err_misalign", 64'(bus.err_misalign), 64'(mf[32]));
        end
      end
    end
  end
  task automatic reset_chk(input string tag);
    chk({tag, "_load_ready"}, 64'(bus.load_ready), 64'd0);
    chk({tag, "_patch_ready"}, 64'(bus.patch_ready), 64'd0);
    chk({tag, "_fetch_valid"}, 64'(bus.fetch_valid), 64'd0);
    chk({tag, "_fetch_stall"}, 64'(bus.fetch_stall), 64'd0);
    chk({tag, "_fetch_inst"}, 64'(bus.fetch_inst), 64'd0);
    chk({tag, "_err_misalign"}, 64'(bus.err_misalign), 64'd0);
    chk({tag, "_err_overflow"}, 64'(bus.err_overflow), 64'd0);
    chk({tag, "_load_count"}, 64'(bus.load_count), 64'd0);
    chk({tag, "_cpu_rst_hold"}, 64'(bus.cpu_rst_hold), 64'd1);
  endtask
  task automatic load_seq(input int n, input bit with_last);
    int i = 0;
    int guard = 0;
    bit acc;
    while (i < n && guard < 200) begin
      bus.load_valid = $urandom_range(0, 3) != 0;
      bus.load_data = words[i];
      bus.load_last = with_last && i == n - 1;
      acc = ph == 1 && bus.load_valid;
      step();
      if (acc) i++;
      guard++;
    end
    chk("load_seq_done", 64'(i), 64'(n));
    bus.load_valid = 1'b0; bus.load_last = 1'b0;
  endtask
  task automatic fetch1(input logic [31:0] a);
    bus.fetch_req = 1'b1; bus.fetch_addr = a;
    step();
    bus.fetch_req = 1'b0;
    step();
  endtask
  task automatic fetch2(input logic [31:0] a, input logic [31:0] exp);
    bus2.fetch_req = 1'b1; bus2.fetch_addr = a;
    @(negedge clk) chk("ovf_fetch_stall", 64'(bus2.fetch_stall), 64'd0);
    @(posedge clk); #1;
    bus2.fetch_req = 1'b0;
    @(negedge clk);
    chk("ovf_fetch_valid", 64'(bus2.fetch_valid), 64'd1);
    chk("ovf_fetch_inst", 64'(bus2.fetch_inst), 64'(exp));
    @(posedge clk); #1;
  endtask
  initial begin
    int pcount, guard, wa;
    {bus.boot_skip, bus.load_valid, bus.load_last, bus.reload, bus.patch_valid, bus.fetch_req} = '0;
    bus.load_data = '0; bus.patch_addr = '0; bus.patch_data = '0; bus.fetch_addr = '0;
    {bus2.boot_skip, bus2.load_valid, bus2.load_last, bus2.reload, bus2.patch_valid, bus2.fetch_req} = '0;
    bus2.load_data = '0; bus2.patch_addr = '0; bus2.patch_data = '0; bus2.fetch_addr = '0;
    #2 rst = 1'b0; rst2 = 1'b0;
    #1 reset_chk("por");
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    words = '{32'hE3A00014, 32'hE3A01A01, 32'hE3A02103, 32'hE0923002};
    load_seq(4, 1'b1);
    chk("boot_count", 64'(bus.load_count), 64'd4);
    for (int i = 0; i < 4; i++) fetch1(32'(i * 4));
    // patch/fetch contention with fetch held at 0x8
    bus.fetch_req = 1'b1; bus.fetch_addr = 32'h8; pcount = 0; guard = 0;
    while (pcount < 6 && guard < 40) begin
      bus.patch_valid = 1'b1;
      bus.patch_addr = 32'($urandom_range(16, 31) * 4);
      bus.patch_data = $urandom;
      step();
      if (last_pg) pcount++;
      guard++;
    end
    chk("contention_patches", 64'(pcount), 64'd6);
    bus.fetch_req = 1'b0; bus.patch_valid = 1'b0;
    step();
    step();
    // same-address collision: patch wins, fetch returns new data
    bus.patch_valid = 1'b1; bus.patch_addr = 32'h8; bus.patch_data = 32'hDEADBEEF;
    bus.fetch_req = 1'b1; bus.fetch_addr = 32'h8;
    step();
    bus.patch_valid = 1'b0;
    step();
    bus.fetch_req = 1'b0;
    step();
    step();
    fetch1(32'h6);
    // randomized traffic with upper address bits scrambled
    for (int c = 0; c < 300; c++) begin
      bus.patch_valid = $urandom_range(0, 2) != 0;
      bus.patch_addr = {14'($urandom), 16'($urandom_range(0, 63)), 2'($urandom)};
      bus.patch_data = $urandom;
      wa = known[$urandom_range(0, known.size() - 1)];
      bus.fetch_req = $urandom_range(0, 3) != 0;
      bus.fetch_addr = {14'($urandom), 16'(wa), 2'($urandom)};
      step();
    end
    bus.patch_valid = 1'b0; bus.fetch_req = 1'b0;
    step();
    // reload with a read in flight
    bus.fetch_req = 1'b1; bus.fetch_addr = 32'h4;
    step();
    bus.reload = 1'b1;
    step();
    bus.reload = 1'b0; bus.fetch_req = 1'b0;
    words = '{$urandom, $urandom, $urandom, $urandom};
    load_seq(3, 1'b1);
    fetch1(32'h8);
    // reset in the middle of a load
    bus.reload = 1'b1;
    step();
    bus.reload = 1'b0;
    words = '{$urandom, $urandom, $urandom, $urandom};
    load_seq(2, 1'b0);
    #2 mon_en = 1'b0; bus.fetch_req = 1'b1; rst = 1'b0;
    model_reset();
    #1 reset_chk("midload");
    bus.fetch_req = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    bus.boot_skip = 1'b1;
    step();
    bus.boot_skip = 1'b0;
    for (int i = 0; i < 3; i++) fetch1(32'(i * 4));
    mon_en = 1'b0;
    chk("fetch_queue_drained", 64'(fq.size()), 64'd0);
    // overflow on the 4-word instance: five words, no last marker
    @(negedge clk) rst2 = 1'b1;
    @(posedge clk); #1;
    bus2.load_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      bus2.load_data = 32'h1000 + 32'(c);
      @(negedge clk) chk("ovf_load_ready", 64'(bus2.load_ready), 64'(c >= 1 && c <= 4));
      @(posedge clk); #1;
    end
    bus2.load_valid = 1'b0;
    @(negedge clk);
    chk("ovf_err_overflow", 64'(bus2.err_overflow), 64'd1);
    chk("ovf_load_count", 64'(bus2.load_count), 64'd4);
    chk("ovf_cpu_rst_hold", 64'(bus2.cpu_rst_hold), 64'd0);
    @(posedge clk); #1;
    fetch2(32'h0, 32'h1001);
    fetch2(32'hC, 32'h1004);
    fetch2(32'h1C, 32'h1004);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
